// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter: a bank of N clocked SR bits shared by two requesters
// through a round-robin arbiter. Each transaction is a SET, RESET or HOLD
// (read) of one addressed bit, run as IDLE -> EXEC -> ACK.
// The S=R=1 op (11) is never applied to the storage. By default it is
// rejected with ERR. Define SR_BANK_TOGGLE_EN to remap it to a toggle of
// the addressed bit instead.
module sr_bank_arbiter #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ0,
  input  logic [1:0]    OP0,
  input  logic [AW-1:0] ADDR0,
  output logic          ACK0,
  input  logic          REQ1,
  input  logic [1:0]    OP1,
  input  logic [AW-1:0] ADDR1,
  output logic          ACK1,
  output logic          RDATA,
  output logic          ERR,
  output logic          BUSY,
  output logic [N-1:0]  Q,
  output logic [N-1:0]  QBAR
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_ILLEGL = 2'b11;

  // Widened so the compare still works when 2**AW == N.
  localparam logic [AW:0] N_W = (AW+1)'(N);

  state_t        state_q, state_d;
  logic          id_q, id_d;       // winner of the current transaction
  logic          last_q, last_d;   // winner of the previous transaction
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_q, err_d;
  logic [N-1:0]  q_q, q_d;

  logic          grant1;
  logic          wr_en;
  logic          wr_val;
  logic          addr_ok;
  logic          cur_bit;
  logic [N-1:0]  addr_hit;

  assign addr_ok = ({1'b0, addr_q} < N_W);

  // One-hot decode of the latched address; all zero when out of range,
  // so reads of an invalid address return 0 and writes touch nothing.
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign addr_hit[gi] = (addr_q == AW'(gi));
    assign q_d[gi]      = (wr_en && addr_hit[gi]) ? wr_val : q_q[gi];
  end

  assign cur_bit = |(q_q & addr_hit);

  // Next-state, arbitration and bank write control.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    op_d    = op_q;
    addr_d  = addr_q;
    err_d   = err_q;
    grant1  = 1'b0;
    wr_en   = 1'b0;
    wr_val  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (REQ0 || REQ1) begin
          // On a tie the requester that did not win last time goes next.
          grant1  = (REQ0 && REQ1) ? ~last_q : REQ1;
          id_d    = grant1;
          op_d    = grant1 ? OP1 : OP0;
          addr_d  = grant1 ? ADDR1 : ADDR0;
          err_d   = 1'b0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        err_d   = 1'b0;
        state_d = ST_ACK;
        if (!addr_ok) begin
          err_d = 1'b1;
        end else begin
          case (op_q)
            OP_HOLD: begin
              wr_en = 1'b0;
            end
            OP_RESET: begin
              wr_en  = 1'b1;
              wr_val = 1'b0;
            end
            OP_SET: begin
              wr_en  = 1'b1;
              wr_val = 1'b1;
            end
            OP_ILLEGL: begin
`ifdef SR_BANK_TOGGLE_EN
              wr_en  = 1'b1;
              wr_val = ~cur_bit;
`else
              err_d  = 1'b1;
`endif
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end
      end
      ST_ACK: begin
        last_d  = id_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset aborts any transaction in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= 2'b00;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // SR storage bank; only the addressed bit can change, and only in EXEC.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign ACK0  = (state_q == ST_ACK) && !id_q;
  assign ACK1  = (state_q == ST_ACK) &&  id_q;
  assign ERR   = (state_q == ST_ACK) && err_q;
  assign RDATA = (state_q == ST_ACK) && cur_bit;
  assign BUSY  = (state_q != ST_IDLE);
  assign Q     = q_q;
  assign QBAR  = ~q_q;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed testbench for sr_bank_arbiter. A second instance with N=6
// shares the stimulus and is checked for out-of-range address handling.
module tb_sr_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] op0 = 2'b00, op1 = 2'b00;
  logic [2:0] addr0 = 3'd0, addr1 = 3'd0;

  logic       ack0, ack1, rdata, err, busy;
  logic [7:0] q, qbar;
  logic       ack0_6, ack1_6, rdata_6, err_6, busy_6;
  logic [5:0] q6, qbar6;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sr_bank_arbiter #(.N(8), .AW(3)) dut (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .OP0(op0), .ADDR0(addr0), .ACK0(ack0),
    .REQ1(req1), .OP1(op1), .ADDR1(addr1), .ACK1(ack1),
    .RDATA(rdata), .ERR(err), .BUSY(busy), .Q(q), .QBAR(qbar)
  );

  sr_bank_arbiter #(.N(6), .AW(3)) dut6 (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .OP0(op0), .ADDR0(addr0), .ACK0(ack0_6),
    .REQ1(req1), .OP1(op1), .ADDR1(addr1), .ACK1(ack1_6),
    .RDATA(rdata_6), .ERR(err_6), .BUSY(busy_6), .Q(q6), .QBAR(qbar6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request from an IDLE cycle and stop inside the ACK cycle.
  task automatic start_txn(input logic who, input logic [1:0] op, input logic [2:0] addr);
    if (!who) begin
      req0 = 1'b1; op0 = op; addr0 = addr;
    end else begin
      req1 = 1'b1; op1 = op; addr1 = addr;
    end
    tick();
    tick();
  endtask

  // Drop requests after ACK and step into the following IDLE cycle.
  task automatic finish_txn();
    $display("txn: ack0=%0b ack1=%0b rdata=%0b err=%0b q=%h q6=%h",
             ack0, ack1, rdata, err, q, q6);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++; if (q !== 8'h00) $display("FAIL reset_q: got %h want %h", q, 8'h00); else pass_cnt++;
    total_cnt++; if (qbar !== 8'hFF) $display("FAIL reset_qbar: got %h want %h", qbar, 8'hFF); else pass_cnt++;
    total_cnt++; if ({ack0, ack1, rdata, err, busy} !== 5'b0) $display("FAIL reset_outs: got %b want %b", {ack0, ack1, rdata, err, busy}, 5'b0); else pass_cnt++;
    rst = 1'b0;
    $display("txn: reset");
  endtask

  task automatic test_set();
    req0 = 1'b1; op0 = 2'b10; addr0 = 3'd3;
    tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL set_busy_exec: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (ack0 !== 1'b0) $display("FAIL set_ack_exec: got %b want 0", ack0); else pass_cnt++;
    total_cnt++; if (q !== 8'h00) $display("FAIL set_q_exec: got %h want %h", q, 8'h00); else pass_cnt++;
    tick();
    total_cnt++; if (q !== 8'h08) $display("FAIL set_q: got %h want %h", q, 8'h08); else pass_cnt++;
    total_cnt++; if (qbar !== 8'hF7) $display("FAIL set_qbar: got %h want %h", qbar, 8'hF7); else pass_cnt++;
    total_cnt++; if ({ack0, ack1} !== 2'b10) $display("FAIL set_ack: got %b want %b", {ack0, ack1}, 2'b10); else pass_cnt++;
    total_cnt++; if (rdata !== 1'b1) $display("FAIL set_rdata: got %b want 1", rdata); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL set_err: got %b want 0", err); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL set_busy_ack: got %b want 1", busy); else pass_cnt++;
    finish_txn();
    total_cnt++; if ({ack0, rdata, busy} !== 3'b000) $display("FAIL set_idle: got %b want %b", {ack0, rdata, busy}, 3'b000); else pass_cnt++;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL set_stay_idle: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_fairness();
    logic exp0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; op0 = 2'b10; addr0 = 3'd0;
    req1 = 1'b1; op1 = 2'b10; addr1 = 3'd1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      exp0 = ((k % 2) == 0);
      total_cnt++; if ({ack0, ack1} !== {exp0, ~exp0}) $display("FAIL fair_grant%0d: got %b want %b", k, {ack0, ack1}, {exp0, ~exp0}); else pass_cnt++;
      if (k == 1) begin
        total_cnt++; if (q !== 8'h03) $display("FAIL fair_q: got %h want %h", q, 8'h03); else pass_cnt++;
      end
      $display("txn: fair k=%0d ack0=%0b ack1=%0b q=%h", k, ack0, ack1, q);
      tick();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL fair_idle: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_hold();
    start_txn(1'b0, 2'b10, 3'd3);
    total_cnt++; if (q !== 8'h0B) $display("FAIL rh_set3: got %h want %h", q, 8'h0B); else pass_cnt++;
    finish_txn();
    start_txn(1'b1, 2'b01, 3'd3);
    total_cnt++; if ({ack0, ack1} !== 2'b01) $display("FAIL rh_reset_ack: got %b want %b", {ack0, ack1}, 2'b01); else pass_cnt++;
    total_cnt++; if (q !== 8'h03) $display("FAIL rh_reset_q: got %h want %h", q, 8'h03); else pass_cnt++;
    total_cnt++; if ({rdata, err} !== 2'b00) $display("FAIL rh_reset_rd: got %b want %b", {rdata, err}, 2'b00); else pass_cnt++;
    finish_txn();
    start_txn(1'b1, 2'b00, 3'd3);
    total_cnt++; if (q !== 8'h03) $display("FAIL rh_hold_q: got %h want %h", q, 8'h03); else pass_cnt++;
    total_cnt++; if ({ack1, rdata, err} !== 3'b100) $display("FAIL rh_hold_rd: got %b want %b", {ack1, rdata, err}, 3'b100); else pass_cnt++;
    finish_txn();
    start_txn(1'b1, 2'b00, 3'd1);
    total_cnt++; if ({ack1, rdata, q} !== {2'b11, 8'h03}) $display("FAIL rh_hold_one: got %b want %b", {ack1, rdata, q}, {2'b11, 8'h03}); else pass_cnt++;
    finish_txn();
    start_txn(1'b0, 2'b01, 3'd0);
    finish_txn();
    start_txn(1'b1, 2'b01, 3'd1);
    total_cnt++; if (q !== 8'h00) $display("FAIL rh_clear: got %h want %h", q, 8'h00); else pass_cnt++;
    finish_txn();
  endtask

  task automatic test_toggle();
    start_txn(1'b0, 2'b11, 3'd2);
    total_cnt++; if (ack0 !== 1'b1) $display("FAIL tog_ack: got %b want 1", ack0); else pass_cnt++;
`ifdef SR_BANK_TOGGLE_EN
    total_cnt++; if ({q, err, rdata} !== {8'h04, 2'b01}) $display("FAIL tog_first: got %b want %b", {q, err, rdata}, {8'h04, 2'b01}); else pass_cnt++;
`else
    total_cnt++; if ({q, err, rdata} !== {8'h00, 2'b10}) $display("FAIL tog_first: got %b want %b", {q, err, rdata}, {8'h00, 2'b10}); else pass_cnt++;
`endif
    finish_txn();
    total_cnt++; if (err !== 1'b0) $display("FAIL tog_err_idle: got %b want 0", err); else pass_cnt++;
    start_txn(1'b0, 2'b11, 3'd2);
`ifdef SR_BANK_TOGGLE_EN
    total_cnt++; if ({q, err, rdata} !== {8'h00, 2'b00}) $display("FAIL tog_second: got %b want %b", {q, err, rdata}, {8'h00, 2'b00}); else pass_cnt++;
`else
    total_cnt++; if ({q, err, rdata} !== {8'h00, 2'b10}) $display("FAIL tog_second: got %b want %b", {q, err, rdata}, {8'h00, 2'b10}); else pass_cnt++;
`endif
    finish_txn();
  endtask

  task automatic test_range();
    start_txn(1'b0, 2'b10, 3'd7);
    total_cnt++; if (ack0_6 !== 1'b1) $display("FAIL rng_ack6: got %b want 1", ack0_6); else pass_cnt++;
    total_cnt++; if ({err_6, rdata_6} !== 2'b10) $display("FAIL rng_err6: got %b want %b", {err_6, rdata_6}, 2'b10); else pass_cnt++;
    total_cnt++; if (q6 !== 6'h00) $display("FAIL rng_q6: got %h want %h", q6, 6'h00); else pass_cnt++;
    total_cnt++; if ({q, err, rdata} !== {8'h80, 2'b01}) $display("FAIL rng_q8: got %b want %b", {q, err, rdata}, {8'h80, 2'b01}); else pass_cnt++;
    finish_txn();
    total_cnt++; if (err_6 !== 1'b0) $display("FAIL rng_err6_idle: got %b want 0", err_6); else pass_cnt++;
    start_txn(1'b0, 2'b01, 3'd7);
    total_cnt++; if ({q, err_6} !== {8'h00, 1'b1}) $display("FAIL rng_clear: got %b want %b", {q, err_6}, {8'h00, 1'b1}); else pass_cnt++;
    finish_txn();
  endtask

  task automatic test_back_to_back();
    req0 = 1'b1; op0 = 2'b10; addr0 = 3'd1;
    tick();
    tick();
    total_cnt++; if ({ack0, rdata, q} !== {2'b11, 8'h02}) $display("FAIL b2b_first: got %b want %b", {ack0, rdata, q}, {2'b11, 8'h02}); else pass_cnt++;
    $display("txn: b2b first q=%h", q);
    op0 = 2'b01;
    tick();
    total_cnt++; if ({busy, ack0, rdata} !== 3'b000) $display("FAIL b2b_idle: got %b want %b", {busy, ack0, rdata}, 3'b000); else pass_cnt++;
    tick();
    op0 = 2'b10; addr0 = 3'd4;
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_exec: got %b want 1", busy); else pass_cnt++;
    tick();
    total_cnt++; if ({ack0, ack1, rdata, q} !== {3'b100, 8'h00}) $display("FAIL b2b_second: got %b want %b", {ack0, ack1, rdata, q}, {3'b100, 8'h00}); else pass_cnt++;
    finish_txn();
  endtask

  task automatic test_abort();
    req0 = 1'b1; op0 = 2'b10; addr0 = 3'd5;
    tick();
    total_cnt++; if (busy !== 1'b1) $display("FAIL abort_exec: got %b want 1", busy); else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++; if ({q, ack0, busy} !== {8'h00, 2'b00}) $display("FAIL abort_reset: got %b want %b", {q, ack0, busy}, {8'h00, 2'b00}); else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++; if ({busy, ack0, q} !== {2'b10, 8'h00}) $display("FAIL abort_rerun_exec: got %b want %b", {busy, ack0, q}, {2'b10, 8'h00}); else pass_cnt++;
    tick();
    total_cnt++; if ({ack0, rdata, err, q} !== {3'b110, 8'h20}) $display("FAIL abort_rerun_ack: got %b want %b", {ack0, rdata, err, q}, {3'b110, 8'h20}); else pass_cnt++;
    total_cnt++; if ({q6, err_6, rdata_6} !== {6'h20, 2'b01}) $display("FAIL abort_n6_top: got %b want %b", {q6, err_6, rdata_6}, {6'h20, 2'b01}); else pass_cnt++;
    finish_txn();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    test_reset();
    test_set();
    test_fairness();
    test_reset_hold();
    test_toggle();
    test_range();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sr_bank_arbiter.md
Name: sr_bank_arbiter

Overview:
- Owns a bank of N clocked SR storage bits and shares it between two requesters through a round-robin arbiter.
- Each transaction is one SET, RESET or HOLD/read of one addressed bit.
- The controller never drives S=R=1 into a bit; that combination is rejected, or remapped when the optional feature is compiled in.
- Sits between lab-level control logic and the SR storage, so the storage stays legal and race-free.

Parameters:
N, 8, number of SR bits in the bank
AW, 3, address width; must satisfy 2**AW >= N

Ports:
CLK  input  1  single clock, all state updates on rising edge
RST  input  1  synchronous reset, active-high
REQ0  input  1  requester 0 transaction request (level)
OP0  input  2  requester 0 op: 00 HOLD, 01 RESET bit, 10 SET bit, 11 S=R=1 (illegal)
ADDR0  input  AW  requester 0 bit address
ACK0  output  1  one-cycle completion pulse to requester 0
REQ1  input  1  requester 1 transaction request (level)
OP1  input  2  requester 1 op, same encoding as OP0
ADDR1  input  AW  requester 1 bit address
ACK1  output  1  one-cycle completion pulse to requester 1
RDATA  output  1  addressed bit value after the op; valid while ACKx=1
ERR  output  1  high with ACKx when the op was rejected
BUSY  output  1  high in EXEC and ACK states
Q  output  N  bank contents
QBAR  output  N  bitwise complement of Q, always ~Q

Behaviour:
- Reset (synchronous, checked every edge, overrides everything):
  - Q=0, QBAR=all ones, ACK0=ACK1=0, RDATA=0, ERR=0, BUSY=0.
  - State goes to IDLE and LAST (round-robin pointer) goes to 1.
  - Reset in EXEC or ACK aborts the transaction: no bank update, no ACK.
- FSM states: IDLE, EXEC, ACK.
- IDLE:
  - REQ0/REQ1 are sampled on each edge.
  - If exactly one is high, that requester wins.
  - If both are high, the requester other than LAST wins; after reset requester 0 wins the first tie.
  - The winner's id, OP and ADDR are latched into internal registers, and the state goes to EXEC.
  - With no request, the state stays in IDLE.
- EXEC (1 cycle):
  - Bit update at the edge ending EXEC, using the latched values:
    - SET: Q[addr]=1.
    - RESET: Q[addr]=0.
    - HOLD: no change.
  - Op 11 with the optional feature off, or ADDR >= N with any op: no change, and ERR is flagged.
  - The state goes to ACK.
- ACK (1 cycle):
  - ACK of the winner is 1 and the other ACK is 0.
  - RDATA = post-update Q[addr]; RDATA = 0 when ADDR >= N.
  - ERR as flagged in EXEC.
  - LAST = winner id at the edge ending ACK.
  - The state goes to IDLE.
- Latency:
  - A request sampled at edge t0 gives ACK high during cycle t0+1..t0+2.
  - Q changes at t0+1.
  - Throughput is one transaction per 3 cycles.
- Handshake:
  - The requester holds REQ/OP/ADDR stable until it sees ACK.
  - It must drop REQ before the edge ending the first IDLE cycle after ACK.
  - REQ still high at that sample starts a new transaction, so back-to-back transactions are legal.
  - Changes to OP/ADDR after the IDLE sample are ignored.
- Fairness: under continuous requests from both sides, grants strictly alternate 0,1,0,1...
- The loser's REQ is untouched and is served next.
- ACK0 and ACK1 are never high in the same cycle.
- Q bits not addressed hold their value in all cases.
- RDATA and ERR are 0 outside ACK.

Optional Feature:
SR_BANK_TOGGLE_EN
- Defined: op 11 toggles the bit, Q[addr] = ~Q[addr], JK-style; ERR is not raised for op 11.
- Undefined: op 11 is rejected, the bank is unchanged, and ERR=1 with the ACK pulse.
- The ADDR >= N rejection applies in both builds.

Test Plan:
- Reset then REQ0=1, OP0=10, ADDR0=3 at t0 -> Q=0x08 at t0+1, ACK0=1 and RDATA=1 in the following cycle, ERR=0, BUSY=1 for 2 cycles.
- Reset then REQ0=REQ1=1 held, OP0=10 ADDR0=0, OP1=10 ADDR1=1 -> grants 0,1,0,1; ACK pulses alternate every 3 cycles; Q=0x03 after the first two transactions.
- Q=0x08, REQ1 with OP1=01 ADDR1=3 -> Q=0x00, RDATA=0 with ACK1; then OP1=00 ADDR1=3 -> Q unchanged, RDATA=0.
- OP0=11 ADDR0=2 on Q=0x00:
  - Macro off -> Q=0x00, ERR=1 with ACK0.
  - Macro on -> Q=0x04, ERR=0; repeating the op gives Q=0x00.
- N=6, ADDR0=7, OP0=10 -> Q unchanged, ERR=1, RDATA=0 with ACK0.
- REQ0 SET ADDR0=5, RST=1 asserted in the EXEC cycle -> Q=0x00, no ACK0, state IDLE; REQ0 still high after RST drops -> transaction reruns with normal latency.
